fnd_scan_ctrl: RTL and testbench
================================

Name: fnd_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 8-digit common-row 7-segment (FND) display.
- Walks an enable mask of digits, inserts an anti-ghosting blanking interval before each digit slot, and drives a one-hot row select plus active-low segment lines.
- Segment patterns arrive through a valid/ready write port into a shadow buffer; the active buffer swaps only at frame boundaries, so a frame never shows mixed old/new data.
- Sits between the design's hex/segment decoders and the FND pins.

Parameters:
- SCAN_DIV, 4096: clk cycles per digit slot (blank plus drive); must be ≥ 2.
- BLANK_CYC, 256: leading cycles of each slot with all rows off; must be < SCAN_DIV; 0 means no blanking.
- CNT_W, 13: width of the slot counter; must satisfy 2^CNT_W ≥ SCAN_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- digit_en  in  8  bit i=1 scans digit i; sampled only at slot start.
- wr_valid  in  1  new frame pattern offered.
- wr_ready  out  1  shadow buffer free.
- wr_data  in  64  byte i = digit i segments, active-high, bit order {a,b,c,d,e,f,g,dp} MSB..LSB.
- fnd_row  out  8  one-hot digit select, active-high.
- seg_n  out  8  active-low segments {A..G,DP} for the selected digit.
- frame_done  out  1  one-cycle pulse on each active-buffer commit point.

Behaviour:
- Reset (async): fnd_row=8'h00, seg_n=8'hFF, wr_ready=1, frame_done=0, active and shadow buffers = 0, pending=0, cursor=7, slot_cnt=0, state=IDLE.
- States: IDLE, BLANK, DRIVE. All outputs registered; an output changes on the same edge that enters the state or phase.
- IDLE: fnd_row=0, seg_n=FF.
  - If digit_en≠0 → slot start.
  - While in IDLE, a pending shadow commits on the next edge, with a frame_done pulse.
- Slot start:
  - next = lowest enabled index strictly greater than cursor, else lowest enabled index (wrap); cursor←next; slot_cnt←0.
  - If next ≤ old cursor (wrap; includes the first slot after reset or IDLE, since cursor=7), this is a frame start: active←shadow if pending, pending←0, frame_done=1 this cycle.
- Slot start enters BLANK; if BLANK_CYC=0 it enters DRIVE directly.
- BLANK: fnd_row=0, seg_n=FF for BLANK_CYC cycles.
- DRIVE: fnd_row=1<<cursor, seg_n=~active[cursor] for SCAN_DIV−BLANK_CYC cycles.
- Slot end (slot_cnt==SCAN_DIV−1):
  - If sampled digit_en==0 → IDLE, outputs blanked next edge.
  - Otherwise → next slot start.
- Slot period is exactly SCAN_DIV cycles; no dead cycle between slots.
- Write handshake:
  - Transfer when wr_valid && wr_ready: shadow←wr_data, pending←1, wr_ready←0 next cycle.
  - wr_ready returns to 1 on the cycle after commit.
  - A transfer on the same edge as a commit loads the shadow; that data waits for the next frame start.
- digit_en changes mid-slot have no effect until the next slot start.
- With a single enabled digit, every slot is a frame start.
- Unselected rows are always 0; at most one fnd_row bit is ever high.

Test Plan:
- Reset, SCAN_DIV=16, BLANK_CYC=4, digit_en=8'h0B → row sequence 01,02,08,01… Each slot has 4 cycles of fnd_row=0 then 12 cycles one-hot; frame_done at each slot start of digit 0.
- Write wr_data byte0=8'hFC, others 0, issued mid-frame → wr_ready drops the next cycle. seg_n stays FF for digit 0 until the next frame start, then becomes 8'h03. wr_ready rises one cycle after frame_done.
- digit_en 8'h0B→8'h00 during a DRIVE slot → slot completes, then IDLE with fnd_row=0, seg_n=FF. Restoring 8'h04 → row 04 after blanking, with frame_done on that slot start.
- digit_en=8'h80 only, BLANK_CYC=0 → fnd_row=80 continuously, frame_done every 16 cycles.
- Assert rst mid-DRIVE → outputs 00/FF immediately (async), buffers cleared, wr_ready=1.
- Back-to-back writes A then B within one frame → B held (wr_ready low) until A commits, then B commits at the following frame start. Two frame_done pulses, with no mixed-frame segment data.

Source files
------------

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: time-multiplexed scan controller for an 8-digit common-row
// 7-segment display. Walks the digit enable mask, blanks all rows at the
// head of each slot, and shows segment data from an active buffer that is
// refreshed from a write-port shadow buffer only at frame boundaries.
module fnd_scan_ctrl #(
  parameter int SCAN_DIV  = 4096,
  parameter int BLANK_CYC = 256,
  parameter int CNT_W     = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  digit_en,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [63:0] wr_data,
  output logic [7:0]  fnd_row,
  output logic [7:0]  seg_n,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_cursor;
  logic [63:0]      r_active;
  logic [63:0]      r_shadow;
  logic             r_pending;
  logic             r_wr_ready;
  logic [7:0]       r_row;
  logic [7:0]       r_seg;
  logic             r_fd;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_cursor_nxt;
  logic [7:0]       w_row_nxt;
  logic [7:0]       w_seg_nxt;
  logic             w_fd_nxt;
  logic [2:0]       w_next_cur;
  logic [2:0]       w_lo;
  logic [2:0]       w_hi;
  logic             w_lo_found;
  logic             w_hi_found;
  logic             w_slot_start;
  logic             w_frame_start;
  logic             w_commit;
  logic             w_xfer;
  logic [63:0]      w_active_nxt;

  assign wr_ready   = r_wr_ready;
  assign fnd_row    = r_row;
  assign seg_n      = r_seg;
  assign frame_done = r_fd;
  assign w_xfer     = wr_valid && r_wr_ready;

  // Pick the next enabled digit after the cursor, wrapping to the lowest one.
  always_comb begin
    w_lo       = '0;
    w_hi       = '0;
    w_lo_found = 1'b0;
    w_hi_found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (digit_en[i] && !w_lo_found) begin
        w_lo       = 3'(i);
        w_lo_found = 1'b1;
      end
      if (digit_en[i] && (3'(i) > r_cursor) && !w_hi_found) begin
        w_hi       = 3'(i);
        w_hi_found = 1'b1;
      end
    end
    w_next_cur = w_hi_found ? w_hi : w_lo;
  end

  // Next-state and next-output logic; outputs are computed here and registered.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_cursor_nxt  = r_cursor;
    w_row_nxt     = '0;
    w_seg_nxt     = '1;
    w_slot_start  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (digit_en != '0) w_slot_start = 1'b1;
      end
      BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = DRIVE;
          w_row_nxt   = 8'b1 << r_cursor;
          w_seg_nxt   = ~r_active[{r_cursor, 3'b000} +: 8];
        end
      end
      DRIVE: begin
        if (r_cnt == SLOT_LAST) begin
          if (digit_en == '0) begin
            // Parking the cursor at 7 makes the next wake-up a frame start.
            w_state_nxt  = IDLE;
            w_cursor_nxt = 3'd7;
            w_cnt_nxt    = '0;
          end else begin
            w_slot_start = 1'b1;
          end
        end else begin
          w_row_nxt = 8'b1 << r_cursor;
          w_seg_nxt = ~r_active[{r_cursor, 3'b000} +: 8];
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_frame_start = w_slot_start && (w_next_cur <= r_cursor);
    w_commit      = r_pending && (w_frame_start || (r_state == IDLE));
    w_fd_nxt      = w_frame_start || w_commit;
    w_active_nxt  = w_commit ? r_shadow : r_active;

    if (w_slot_start) begin
      w_cursor_nxt = w_next_cur;
      w_cnt_nxt    = '0;
      if (BLANK_CYC == 0) begin
        // No blanking: the slot opens straight into DRIVE with freshly committed data.
        w_state_nxt = DRIVE;
        w_row_nxt   = 8'b1 << w_next_cur;
        w_seg_nxt   = ~w_active_nxt[{w_next_cur, 3'b000} +: 8];
      end else begin
        w_state_nxt = BLANK;
      end
    end
  end

  // State, slot counter, cursor and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_cursor <= 3'd7;
      r_row    <= '0;
      r_seg    <= '1;
      r_fd     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cursor <= w_cursor_nxt;
      r_row    <= w_row_nxt;
      r_seg    <= w_seg_nxt;
      r_fd     <= w_fd_nxt;
    end
  end

  // Shadow/active buffers and write handshake; a transfer overrides a same-edge commit of pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active   <= '0;
      r_shadow   <= '0;
      r_pending  <= 1'b0;
      r_wr_ready <= 1'b1;
    end else begin
      if (w_commit) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end
      if (w_xfer) begin
        r_shadow   <= wr_data;
        r_pending  <= 1'b1;
        r_wr_ready <= 1'b0;
      end else if (!r_pending && !r_wr_ready) begin
        r_wr_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: stimulus pushes expected drive phases into a
// queue; a monitor pops one entry each time a row starts being driven.
module tb_fnd_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_valid, wr_ready, frame_done;
  logic [7:0]  digit_en, fnd_row, seg_n;
  logic [63:0] wr_data;

  logic        rst_b, wr_valid_b, wr_ready_b, frame_done_b;
  logic [7:0]  digit_en_b, fnd_row_b, seg_n_b;
  logic [63:0] wr_data_b;

  fnd_scan_ctrl #(.SCAN_DIV(16), .BLANK_CYC(4), .CNT_W(5)) u_dut (
    .clk(clk), .rst(rst), .digit_en(digit_en), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .fnd_row(fnd_row),
    .seg_n(seg_n), .frame_done(frame_done)
  );

  fnd_scan_ctrl #(.SCAN_DIV(16), .BLANK_CYC(0), .CNT_W(5)) u_dut_nb (
    .clk(clk), .rst(rst_b), .digit_en(digit_en_b), .wr_valid(wr_valid_b),
    .wr_ready(wr_ready_b), .wr_data(wr_data_b), .fnd_row(fnd_row_b),
    .seg_n(seg_n_b), .frame_done(frame_done_b)
  );

  typedef struct {
    logic [7:0] row;
    logic [7:0] seg;
    int         blank;  // expected blank cycles before this drive, -1 = don't care
    bit         fd;     // frame_done expected within this slot's blank run
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   n;
  bit   ok;

  localparam logic [63:0] W1 = 64'h0000_0000_0000_00FC;
  localparam logic [63:0] WA = 64'h0000_0000_DA00_60FC;
  localparam logic [63:0] WB = 64'h0000_0000_FCB6_DA60;
  localparam logic [63:0] WC = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] row, input logic [7:0] seg, input int blank, input bit fd);
    exp_t e;
    e.row = row; e.seg = seg; e.blank = blank; e.fd = fd;
    q.push_back(e);
  endtask

  task automatic wait_fd(input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (!frame_done && k < 200);
    chk(name, frame_done, 1'b1);
  endtask

  task automatic wait_fd_b(input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (!frame_done_b && k < 200);
    chk(name, frame_done_b, 1'b1);
  endtask

  // Monitor: checks row/segment invariants and pops one expectation per drive phase.
  logic [7:0] prev_row;
  int         zrun;
  bit         fd_seen;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      prev_row = '0;
      zrun     = 0;
      fd_seen  = 1'b0;
    end else begin
      if (frame_done) fd_seen = 1'b1;
      chk("row_onehot0", ($countones(fnd_row) <= 1), 1'b1);
      if (fnd_row == '0) begin
        chk("blank_seg", seg_n, 8'hFF);
        zrun++;
      end else if (fnd_row != prev_row || zrun != 0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drive_unexpected: got row %0h seg %0h, expected no drive", fnd_row, seg_n);
        end else begin
          e = q.pop_front();
          chk("drive_row", fnd_row, e.row);
          chk("drive_seg", seg_n, e.seg);
          if (e.blank >= 0) chk("blank_len", zrun, e.blank);
          chk("slot_frame_done", fd_seen, e.fd);
        end
        zrun    = 0;
        fd_seen = 1'b0;
      end
      prev_row = fnd_row;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; digit_en = '0; wr_valid = 1'b0; wr_data = '0;
    rst_b = 1'b1; digit_en_b = '0; wr_valid_b = 1'b0; wr_data_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_row", fnd_row, 8'h00);
    chk("rst_seg", seg_n, 8'hFF);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_frame_done", frame_done, 1'b0);

    // Frames 0..4 with mask 0B: rows 01,02,08; data per committed buffer.
    push(8'h01, 8'hFF, -1, 1); push(8'h02, 8'hFF, 4, 0); push(8'h08, 8'hFF, 4, 0);
    push(8'h01, 8'hFF,  4, 1); push(8'h02, 8'hFF, 4, 0); push(8'h08, 8'hFF, 4, 0);
    push(8'h01, 8'h03,  4, 1); push(8'h02, 8'hFF, 4, 0); push(8'h08, 8'hFF, 4, 0);
    push(8'h01, 8'h03,  4, 1); push(8'h02, 8'h9F, 4, 0); push(8'h08, 8'h25, 4, 0);
    push(8'h01, 8'h9F,  4, 1); push(8'h02, 8'h25, 4, 0);
    rst = 1'b0; digit_en = 8'h0B;

    wait_fd("fd0");
    wait_fd("fd1");
    repeat (20) @(negedge clk);
    wr_data = W1; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("wr_ready_drop", wr_ready, 1'b0);

    wait_fd("fd2");
    chk("wr_ready_low_at_commit", wr_ready, 1'b0);
    @(negedge clk);
    chk("wr_ready_rise", wr_ready, 1'b1);

    wr_data = WA; wr_valid = 1'b1;
    @(negedge clk);
    wr_data = WB;
    chk("a_taken", wr_ready, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!wr_ready && n < 200);
    chk("b_hold_cycles", n, 47);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("b_taken", wr_ready, 1'b0);

    wait_fd("fd4");
    repeat (24) @(negedge clk);
    digit_en = '0;
    repeat (16) @(negedge clk);
    chk("idle_row", fnd_row, 8'h00);
    chk("idle_seg", seg_n, 8'hFF);
    chk("idle_frame_done", frame_done, 1'b0);
    chk("idle_wr_ready", wr_ready, 1'b1);

    push(8'h04, 8'h49, -1, 1); push(8'h04, 8'h49, 4, 1);
    digit_en = 8'h04;
    @(negedge clk);
    chk("restore_fd", frame_done, 1'b1);
    repeat (23) @(negedge clk);
    wr_data = WC; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("pre_rst_pending", wr_ready, 1'b0);
    chk("pre_rst_row", fnd_row, 8'h04);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_row", fnd_row, 8'h00);
    chk("async_rst_seg", seg_n, 8'hFF);
    chk("async_rst_wr_ready", wr_ready, 1'b1);
    chk("async_rst_frame_done", frame_done, 1'b0);

    @(negedge clk);
    push(8'h04, 8'hFF, -1, 1); push(8'h04, 8'hFF, 4, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_fd", frame_done, 1'b1);
    repeat (24) @(negedge clk);
    digit_en = '0;
    repeat (16) @(negedge clk);
    chk("final_idle_row", fnd_row, 8'h00);
    chk("queue_drained", q.size(), 0);

    // No-blanking instance, single digit 7.
    rst_b = 1'b0; digit_en_b = 8'h80;
    wait_fd_b("nb_fd_first");
    chk("nb_row", fnd_row_b, 8'h80);
    chk("nb_seg", seg_n_b, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      n = 0; ok = 1'b1;
      do begin
        @(negedge clk); n++;
        if (fnd_row_b !== 8'h80) ok = 1'b0;
      end while (!frame_done_b && n < 100);
      chk("nb_fd_period", n, 16);
      chk("nb_row_steady", ok, 1'b1);
    end
    chk("nb_wr_ready", wr_ready_b, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
